// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM: byte-enabled write port, pipelined read port,
// selectable read-during-write semantics and a post-reset clear engine.
module ram_sdp_be #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 6,
    parameter bit RDW_MODE       = 1'b0,
    parameter bit OUT_REG        = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;

    logic [DATA_WIDTH-1:0] rd_s1_q, rd_s1_d;
    logic                  vld_s1_q;

    assign wr_acc = ready_q & wr_en & ~rst;
    assign rd_acc = ready_q & rd_en & ~rst;
    assign ready  = ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        unique case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // The clear engine owns the write port until the sweep completes.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_be    = wr_be;
        if (!rst && state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else begin
            mem_we = wr_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Write-first mode forwards the enabled bytes of a colliding write.
    always_comb begin
        rd_s1_d = mem[rd_addr];
        if (RDW_MODE && wr_acc && (wr_addr == rd_addr)) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    rd_s1_d[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s1_q  <= '0;
            vld_s1_q <= 1'b0;
        end else begin
            vld_s1_q <= rd_acc;
            if (rd_acc) begin
                rd_s1_q <= rd_s1_d;
            end
        end
    end

    if (OUT_REG) begin : g_oreg
        logic [DATA_WIDTH-1:0] rd_s2_q, rd_s2_d;
        logic                  vld_s2_q, vld_s2_d;

        always_comb begin
            vld_s2_d = vld_s1_q;
            rd_s2_d  = vld_s1_q ? rd_s1_q : rd_s2_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_s2_q  <= '0;
                vld_s2_q <= 1'b0;
            end else begin
                rd_s2_q  <= rd_s2_d;
                vld_s2_q <= vld_s2_d;
            end
        end

        assign rd_data  = rd_s2_q;
        assign rd_valid = vld_s2_q;
    end else begin : g_noreg
        assign rd_data  = rd_s1_q;
        assign rd_valid = vld_s1_q;
    end

endmodule
